// File: rtl/instr_fetch_unit.sv
// Purpose : SimpleRISC front end - owns the PC, fetches 16-bit instructions, latches IR,
//           decodes IR fields and starts the control FSM with s, waiting on w between instructions.
// Latency : IR/pc update on the edge mem_ready is seen; s and decoded fields valid from that edge.
// Backpressure: mem_req/mem_addr held until mem_ready; s held until the FSM drops w; next fetch waits for w=1.
//
// Parameters:
//   PC_WIDTH   program counter / memory address width
//   RESET_PC   PC value loaded on reset
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   mem_req, mem_addr     fetch request and address (mem_addr always equals pc)
//   mem_rdata, mem_ready  instruction word and completion strobe from memory
//   s, w                  start request to / wait-idle status from the control FSM
//   nsel                  one-hot register-field select (100=Rn, 010=Rd, 001=Rm)
//   opcode, ALUop, shift, sximm5, sximm8, readnum, writenum   decoded IR fields
//   pc, halted            current PC, fetch stopped by HALT
// Configuration:
//   IFU_HALT_EN  when defined, a fetched opcode 3'b111 parks the unit in HALT until reset;
//                when undefined, opcode 3'b111 is issued like any other instruction.

module instr_fetch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_ready,
  input  logic                w,
  input  logic [2:0]          nsel,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                s,
  output logic [2:0]          opcode,
  output logic [1:0]          ALUop,
  output logic [1:0]          shift,
  output logic [15:0]         sximm5,
  output logic [15:0]         sximm8,
  output logic [2:0]          readnum,
  output logic [2:0]          writenum,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  typedef enum logic [2:0] {
    FETCH = 3'b000,
    ISSUE = 3'b001,
    RUN   = 3'b010,
    HALT  = 3'b011
  } state_t;

  state_t present_state;
  state_t next_state;

  logic [15:0] ir;
  logic        capture;
  logic        mem_req_c;
  logic        s_c;
  logic [2:0]  reg_sel;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present_state <= FETCH;
    end else begin
      present_state <= next_state;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ------------------------------------------------------------------
  always_comb begin
    next_state = present_state;
    capture    = 1'b0;
    mem_req_c  = 1'b0;
    s_c        = 1'b0;

    case (present_state)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          capture = 1'b1;
`ifdef IFU_HALT_EN
          // Opcode is checked on the incoming word so HALT is entered on the
          // capture edge itself and s never pulses for a HALT instruction.
          next_state = (mem_rdata[15:13] == 3'b111) ? HALT : ISSUE;
`else
          next_state = ISSUE;
`endif
        end
      end

      ISSUE: begin
        s_c = 1'b1;
        // w falling is the FSM's acknowledgement that it has taken the start.
        if (!w) begin
          next_state = RUN;
        end
      end

      RUN: begin
        // w back high means the FSM has finished and is idle again.
        if (w) begin
          next_state = FETCH;
        end
      end

      HALT: begin
`ifdef IFU_HALT_EN
        next_state = HALT;
`else
        next_state = FETCH;
`endif
      end

      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Instruction register and program counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 16'h0000;
      pc <= RESET_PC;
    end else if (capture) begin
      ir <= mem_rdata;
      // Natural PC_WIDTH-bit overflow provides the wrap to zero.
      pc <= pc + PC_WIDTH'(1);
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // The request is gated with reset so it drops combinationally the moment
  // reset rises, abandoning any in-flight fetch.
  assign mem_req  = mem_req_c & ~reset;
  assign mem_addr = pc;
  assign s        = s_c;

`ifdef IFU_HALT_EN
  assign halted = (present_state == HALT);
`else
  assign halted = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Instruction decode (purely combinational from IR)
  // ------------------------------------------------------------------
  assign opcode = ir[15:13];
  assign ALUop  = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // Only a clean one-hot select picks a field; zero or multi-hot gives r0.
  always_comb begin
    reg_sel = 3'b000;
    case (nsel)
      3'b100:  reg_sel = ir[10:8];
      3'b010:  reg_sel = ir[7:5];
      3'b001:  reg_sel = ir[2:0];
      default: reg_sel = 3'b000;
    endcase
  end

  assign readnum  = reg_sel;
  assign writenum = reg_sel;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch with memory wait states,
// the s/w handshake, field decode and sign extension, PC wrap, reset in RUN,
// and opcode 111 handling for whichever IFU_HALT_EN build is compiled.

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        w;
  logic [2:0]  nsel;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [7:0]  pc;
  logic        halted;

  int tests_run;
  int tests_failed;

  instr_fetch_unit #(
    .PC_WIDTH (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .w         (w),
    .nsel      (nsel),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .s         (s),
    .opcode    (opcode),
    .ALUop     (ALUop),
    .shift     (shift),
    .sximm5    (sximm5),
    .sximm8    (sximm8),
    .readnum   (readnum),
    .writenum  (writenum),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full instruction at minimum speed: capture, ack (w=0), done (w=1).
  // Called at a negedge in FETCH with w=1; returns at a negedge in FETCH.
  task automatic run_instr(input logic [15:0] word);
    mem_rdata = word;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    w         = 1'b0;
    @(negedge clk);
    w         = 1'b1;
    @(negedge clk);
  endtask

  // Watchdog: all stimulus is fixed-length, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    w            = 1'b1;
    nsel         = 3'b000;
    mem_ready    = 1'b0;
    mem_rdata    = 16'h0000;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_pc",      pc,      8'h00);
    check("rst_s",       s,       1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_opcode",  opcode,  3'd0);
    check("rst_sximm8",  sximm8,  16'h0000);
    check("rst_halted",  halted,  1'b0);

    reset = 1'b0;
    #1;
    check("rel_mem_req",  mem_req,  1'b1);
    check("rel_mem_addr", mem_addr, 8'h00);

    // ---------------- fetch with two wait states ----------------
    repeat (2) begin
      @(negedge clk);
      check("wait_mem_req", mem_req, 1'b1);
      check("wait_s",       s,       1'b0);
      check("wait_pc",      pc,      8'h00);
    end
    mem_rdata = 16'hD207;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("d207_opcode",  opcode,  3'b110);
    check("d207_aluop",   ALUop,   2'b10);
    check("d207_sximm8",  sximm8,  16'h0007);
    check("d207_sximm5",  sximm5,  16'h0007);
    check("d207_pc",      pc,      8'h01);
    check("d207_s",       s,       1'b1);
    check("d207_mem_req", mem_req, 1'b0);
    nsel = 3'b100; #1;
    check("nsel_rn_read",  readnum,  3'b010);
    check("nsel_rn_write", writenum, 3'b010);
    nsel = 3'b001; #1;
    check("nsel_rm_read",  readnum,  3'b111);
    nsel = 3'b010; #1;
    check("nsel_rd_read",  readnum,  3'b000);
    nsel = 3'b101; #1;
    check("nsel_multi",    readnum,  3'b000);
    nsel = 3'b000; #1;
    check("nsel_zero",     writenum, 3'b000);

    // ---------------- s/w handshake ----------------
    repeat (3) begin
      @(negedge clk);
      check("issue_hold_s",   s,       1'b1);
      check("issue_hold_req", mem_req, 1'b0);
    end
    w = 1'b0;
    @(negedge clk);
    check("run_s",       s,       1'b0);
    check("run_mem_req", mem_req, 1'b0);
    w = 1'b1;
    @(negedge clk);
    check("refetch_req",  mem_req,  1'b1);
    check("refetch_addr", mem_addr, 8'h01);
    check("refetch_s",    s,        1'b0);

    // ---------------- sign extension, mem_ready ignored outside FETCH ----------------
    mem_rdata = 16'hA01A;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_rdata = 16'hFFFF;   // stray ready in ISSUE must not reload IR or bump pc
    @(negedge clk);
    mem_ready = 1'b0;
    check("a01a_opcode", opcode, 3'b101);
    check("a01a_pc",     pc,     8'h02);
    check("a01a_shift",  shift,  2'b11);
    check("a01a_sximm5", sximm5, 16'hFFFA);
    check("a01a_sximm8", sximm8, 16'h001A);
    w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    @(negedge clk);

    mem_rdata = 16'h0080;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("0080_sximm8", sximm8, 16'hFF80);
    check("0080_sximm5", sximm5, 16'h0000);
    check("0080_pc",     pc,     8'h03);
    w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    @(negedge clk);

    // ---------------- PC wrap ----------------
    for (int i = 0; i < 252; i++) begin
      run_instr(16'h0000);
    end
    check("pre_wrap_pc",   pc,       8'hFF);
    check("pre_wrap_addr", mem_addr, 8'hFF);
    mem_rdata = 16'h2000;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("wrap_pc",     pc,     8'h00);
    check("wrap_opcode", opcode, 3'b001);
    w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    @(negedge clk);
    check("wrap_addr", mem_addr, 8'h00);
    check("wrap_req",  mem_req,  1'b1);

    // ---------------- reset asserted in RUN ----------------
    mem_rdata = 16'h5234;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("5234_pc",     pc,     8'h01);
    check("5234_opcode", opcode, 3'b010);
    w = 1'b0;
    @(negedge clk);
    check("5234_run_s", s, 1'b0);
    #2;
    reset = 1'b1;          // mid-cycle, no clock edge
    #1;
    nsel = 3'b100;
    #1;
    check("runrst_pc",      pc,      8'h00);
    check("runrst_s",       s,       1'b0);
    check("runrst_mem_req", mem_req, 1'b0);
    check("runrst_opcode",  opcode,  3'd0);
    check("runrst_readnum", readnum, 3'd0);
    w = 1'b1;
    nsel = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("runrst_rel_req",  mem_req,  1'b1);
    check("runrst_rel_addr", mem_addr, 8'h00);
    check("runrst_rel_s",    s,        1'b0);

    // ---------------- opcode 111 ----------------
    @(negedge clk);
    mem_rdata = 16'hE000;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("e000_pc", pc, 8'h01);
`ifdef IFU_HALT_EN
    check("halt_halted",  halted,  1'b1);
    check("halt_s",       s,       1'b0);
    check("halt_mem_req", mem_req, 1'b0);
    for (int i = 0; i < 10; i++) begin
      w         = ~w;
      mem_ready = 1'b1;
      @(negedge clk);
      check("halt_hold_req",    mem_req, 1'b0);
      check("halt_hold_s",      s,       1'b0);
      check("halt_hold_halted", halted,  1'b1);
      check("halt_hold_pc",     pc,      8'h01);
    end
    mem_ready = 1'b0;
    w         = 1'b1;
    reset     = 1'b1;
    #1;
    check("halt_rst_halted", halted, 1'b0);
    check("halt_rst_pc",     pc,     8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("halt_rel_req", mem_req, 1'b1);
`else
    check("op7_s",      s,       1'b1);
    check("op7_opcode", opcode,  3'b111);
    check("op7_halted", halted,  1'b0);
    check("op7_req",    mem_req, 1'b0);
    w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    @(negedge clk);
    check("op7_refetch_req",  mem_req,  1'b1);
    check("op7_refetch_addr", mem_addr, 8'h01);
    check("op7_refetch_halt", halted,   1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream front end of the SimpleRISC controller. It owns the program counter, fetches 16-bit instructions over a simple request/ready memory handshake, and latches each instruction into the instruction register. It decodes the instruction fields for the control FSM, starts the FSM with `s`, then waits for the FSM's `w` before fetching the next instruction.

## Interface
- `PC_WIDTH`, 8: program counter and memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_rdata`  in  16  instruction word from memory; valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `w`  in  1  FSM is in its wait state and idle.
- `nsel`  in  3  one-hot register-field select from the FSM: 100=Rn, 010=Rd, 001=Rm.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  PC_WIDTH  fetch address; always equals `pc`.
- `s`  out  1  start request to the FSM.
- `opcode`  out  3  IR[15:13].
- `ALUop`  out  2  IR[12:11].
- `shift`  out  2  IR[4:3].
- `sximm5`  out  16  IR[4:0] sign-extended.
- `sximm8`  out  16  IR[7:0] sign-extended.
- `readnum`, `writenum`  out  3 each  register number selected by `nsel`.
- `pc`  out  PC_WIDTH  current PC.
- `halted`  out  1  fetch stopped by a HALT instruction.

## Operation
- The state register is `present_state`, 3 bits. States: FETCH=000, ISSUE=001, RUN=010, HALT=011.
- **FETCH**
  - `mem_req`=1 and `mem_addr`=`pc`; both are held until `mem_ready`.
  - On `mem_ready`=1: IR<=`mem_rdata` and `pc`<=`pc`+1, modulo 2^PC_WIDTH (wraps to 0). Next state is ISSUE.
- **ISSUE**
  - `s`=1, held until the FSM acknowledges by driving `w`=0.
  - When `w`=0, go to RUN.
- **RUN**
  - `s`=0. When `w`=1, go to FETCH.
- `mem_ready` is ignored outside FETCH. IR changes only on a FETCH capture.
- Decode is combinational from IR:
  - `readnum`=`writenum` = IR[10:8] when `nsel`=100, IR[7:5] when 010, IR[2:0] when 001.
  - Any other `nsel` value (including 000 and multi-hot) gives 3'b000.
- Reset values:
  - State FETCH, `pc`=RESET_PC, IR=16'h0000, `s`=0, `halted`=0.
  - `mem_req` is forced to 0 while `reset` is high.
  - Decoded outputs follow IR=0, so all are 0.
- Reset mid-operation, from any state:
  - The FSM and registers return immediately to their reset values.
  - Any outstanding memory request is abandoned; the memory must tolerate a dropped `mem_req`.

## Timing
- Fetch latency is one cycle plus the memory wait. If `mem_ready` is seen at edge N, IR and `pc` update at edge N, `s` is high from N until the acknowledging edge, and decoded fields are valid from N.
- Minimum loop is 3 cycles per instruction (FETCH, ISSUE, RUN), each taking one edge when `mem_ready`, `w`=0 and `w`=1 arrive immediately.
- `mem_req` rises the cycle after leaving RUN or after reset deasserts.
- `s` is never high in the same cycle as `mem_req`.

## Configuration
- Macro: `IFU_HALT_EN`.
- **Defined:**
  - A captured instruction with opcode 3'b111 sends the FSM to HALT instead of ISSUE.
  - `pc` still increments on that capture.
  - In HALT: `s`=0, `mem_req`=0, `halted`=1, until reset.
- **Undefined:**
  - HALT is unreachable and `halted` is tied to 0.
  - Opcode 111 is issued to the FSM like any other instruction.

## Test plan
- **Reset:** assert `reset` mid-cycle, with no clock edge -> `pc`=0, `s`=0, `mem_req`=0, `opcode`=0 immediately. Release -> `mem_req`=1, `mem_addr`=0.
- **Fetch:** `mem_ready` held low 2 cycles, then high with `mem_rdata`=16'hD207 ->
  - after the capture edge: `opcode`=110, `ALUop`=10, `sximm8`=16'h0007, `pc`=1, `s`=1;
  - `nsel`=100 -> `readnum`=010; `nsel`=001 -> `readnum`=111.
- **Handshake:** in ISSUE hold `w`=1 for 3 cycles -> `s` stays 1. Then `w`=0 -> RUN, `s`=0. Then `w`=1 -> FETCH with `mem_addr`=1.
- **Sign extension:** IR=16'hA01A -> `shift`=11, `sximm5`=16'hFFFA, `sximm8`=16'h001A. IR=16'h0080 -> `sximm8`=16'hFF80.
- **Wrap:** `pc`=8'hFF; capture -> `pc`=8'h00, next `mem_addr`=0.
- **Halt and reset in RUN:**
  - With `IFU_HALT_EN`, `mem_rdata`=16'hE000 -> `halted`=1, `s` never asserts, `mem_req`=0 for 10 cycles.
  - Without the macro, the same word -> `s`=1 and `opcode`=111.
  - `reset` asserted during RUN -> state FETCH, `pc`=RESET_PC.
